// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: turns a length-prefixed, big-endian byte stream
// into word writes at BASE_ADDR, BASE_ADDR+4, ... while holding the CPU stalled.
module instr_mem_loader #(
    parameter int          INSTR_MEM_SIZE = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [16:0] MAX_LEN = 17'(INSTR_MEM_SIZE);

    logic [2:0]  state_q,    state_d;
    logic [15:0] len_q,      len_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] asm_q,      asm_d;
    logic [31:0] wr_addr_q,  wr_addr_d;
    logic [31:0] wr_data_q,  wr_data_d;

    logic        xfer;
    logic [15:0] len_full;
    logic [15:0] word_idx_inc;

    assign byte_ready   = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
    assign xfer         = byte_valid && byte_ready;
    assign len_full     = {len_q[15:8], byte_in};
    assign word_idx_inc = word_idx_q + 16'd1;

    assign wr_en    = (state_q == S_WRITE);
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = byte_ready || wr_en;
    assign done     = (state_q == S_DONE);
    assign error    = (state_q == S_ERR);

    // NOTE: every next-state signal gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d   = {byte_in, 8'h00};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d      = len_full;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    if (len_full == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, len_full} > MAX_LEN) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    if (byte_idx_q == 2'd3) begin
                        // Output registers only change here, so they hold steady outside WRITE.
                        wr_data_d  = {asm_q, byte_in};
                        wr_addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                        byte_idx_d = '0;
                        state_d    = S_WRITE;
                    end else begin
                        asm_d      = {asm_q[15:0], byte_in};
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_inc;
                state_d    = (word_idx_inc == len_q) ? S_DONE : S_DATA;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: a stream-level model queues expected
// writes, and a negedge monitor compares every wr_en pulse against the queue.
module tb_instr_mem_loader;

    localparam int          SIZE = 1024;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    instr_mem_loader #(.INSTR_MEM_SIZE(SIZE), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          wr_count = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;
    logic [63:0] sb[$];
    logic [7:0]  stream[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        check("status_onehot0", 32'($onehot0({done, error, cpu_hold})), 32'd1);
        if (wr_en === 1'b1) begin
            wr_count++;
            last_addr = wr_addr;
            last_data = wr_data;
            check("ready_low_in_write", 32'(byte_ready), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_write", 32'(wr_en), 32'd0);
            end else begin
                logic [63:0] exp;
                exp = sb.pop_front();
                check("wr_addr", wr_addr, exp[63:32]);
                check("wr_data", wr_data, exp[31:0]);
            end
        end
    end

    // Reference model: length header, then big-endian words at BASE + 4*i.
    function automatic bit model_push();
        int n;
        n = {stream[0], stream[1]};
        if (n == 0) return 1'b0;
        if (n > SIZE) return 1'b1;
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            w = {stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]};
            sb.push_back({BASE + 32'(4 * i), w});
        end
        return 1'b0;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
        end
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        n = 0;
        while (byte_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (byte_ready !== 1'b1) begin
            check("byte_ready_timeout", 32'(byte_ready), 32'd1);
            byte_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic send_stream(input int gap, input bit rnd);
        foreach (stream[i]) send_byte(stream[i], rnd ? int'($urandom_range(0, gap)) : gap);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hold_after_start", 32'(cpu_hold), 32'd1);
        check("done_cleared", 32'(done), 32'd0);
        check("error_cleared", 32'(error), 32'd0);
    endtask

    task automatic wait_status(input bit exp_err);
        int n;
        n = 0;
        while (!(done === 1'b1 || error === 1'b1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done", 32'(done), 32'(!exp_err));
        check("error", 32'(error), 32'(exp_err));
        check("hold_released", 32'(cpu_hold), 32'd0);
        check("ready_after_end", 32'(byte_ready), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_vals();
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", wr_addr, BASE);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
    endtask

    task automatic make_stream(input int n);
        stream = {};
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
    endtask

    task automatic run_load(input int gap, input bit rnd, input bit with_start);
        bit exp_err;
        exp_err = model_push();
        if (with_start) pulse_start();
        send_stream(gap, rnd);
        wait_status(exp_err);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int base_cnt;

        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;

        // Directed two-word load, back-to-back bytes.
        stream = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
        run_load(0, 1'b0, 1'b1);

        // Zero length: done with no writes.
        base_cnt = wr_count;
        stream = '{8'h00, 8'h00};
        run_load(0, 1'b0, 1'b1);
        check("len0_writes", 32'(wr_count - base_cnt), 32'd0);

        // Oversize length: error, no writes; restart clears error.
        base_cnt = wr_count;
        stream = '{8'h04, 8'h01};
        run_load(0, 1'b0, 1'b1);
        check("oversize_writes", 32'(wr_count - base_cnt), 32'd0);
        pulse_start();
        check("ready_in_len_hi", 32'(byte_ready), 32'd1);
        make_stream(1);
        run_load(0, 1'b0, 1'b0);

        // Single word with 3-cycle gaps between bytes.
        base_cnt = wr_count;
        stream = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        run_load(3, 1'b0, 1'b1);
        check("gap_writes", 32'(wr_count - base_cnt), 32'd1);

        // Reset mid-load after 2 bytes of word 1: only word 0 lands.
        base_cnt = wr_count;
        stream = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        sb.push_back({BASE, 32'h1122_3344});
        pulse_start();
        send_stream(0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_vals();
        repeat (3) @(negedge clk);
        check("midrst_writes", 32'(wr_count - base_cnt), 32'd1);
        check("midrst_sb", 32'(sb.size()), 32'd0);
        make_stream(2);
        run_load(0, 1'b0, 1'b1);

        // Randomised loads, one of them oversize.
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                int big;
                big = $urandom_range(SIZE + 1, 65535);
                stream = {};
                stream.push_back(8'(big >> 8));
                stream.push_back(8'(big));
            end else begin
                make_stream($urandom_range(1, 6));
            end
            run_load(2, 1'b1, 1'b1);
        end

        // Full-size load with incrementing words; a start mid-load is ignored.
        base_cnt = wr_count;
        stream = {};
        stream.push_back(8'(SIZE >> 8));
        stream.push_back(8'(SIZE));
        for (int i = 0; i < SIZE; i++) begin
            stream.push_back(8'(i >> 24));
            stream.push_back(8'(i >> 16));
            stream.push_back(8'(i >> 8));
            stream.push_back(8'(i));
        end
        void'(model_push());
        pulse_start();
        fork
            send_stream(0, 1'b0);
            begin
                repeat (1500) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        wait_status(1'b0);
        check("full_writes", 32'(wr_count - base_cnt), 32'(SIZE));
        check("full_last_addr", last_addr, BASE + 32'h0000_0FFC);
        check("full_last_data", last_data, 32'h0000_03FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
